// File: rtl/jmp_pkg.sv
// Shared jump/branch encodings and helpers for the
// jump resolution unit.
package jmp_pkg;

    typedef enum logic [2:0] {
        JT_BEQ  = 3'b000,
        JT_BNE  = 3'b001,
        JT_JAL  = 3'b010,
        JT_JALR = 3'b011,
        JT_BLT  = 3'b100,
        JT_BGE  = 3'b101,
        JT_BLTU = 3'b110,
        JT_BGEU = 3'b111
    } jmp_type_t;

    function automatic logic is_branch(jmp_type_t t);
        return !(t == JT_JAL || t == JT_JALR);
    endfunction

    function automatic logic branch_taken(
        jmp_type_t t,
        logic      zero,
        logic      lt
    );
        logic r;
        r = 1'b0;
        case (t)
            JT_BEQ:           r = zero;
            JT_BNE:           r = !zero;
            JT_BLT, JT_BLTU:  r = lt;
            JT_BGE, JT_BGEU:  r = !lt;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jmp_branch_pipe.sv
// Shift register carrying in-flight conditional branches
// from issue to condition evaluation.
module jmp_branch_pipe
    import jmp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_stall,
    input  logic            i_push,
    input  jmp_type_t       i_push_type,
    input  logic [XLEN-1:0] i_push_tgt,
    input  logic            i_squash,
    output logic            o_head_valid,
    output jmp_type_t       o_head_type,
    output logic [XLEN-1:0] o_head_tgt,
    output logic            o_any_valid
);

    logic            r_valid [DEPTH];
    jmp_type_t       r_type  [DEPTH];
    logic [XLEN-1:0] r_tgt   [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_type[k]  <= JT_BEQ;
                r_tgt[k]   <= '0;
            end
        end else if (!i_stall) begin
            // A taken head kills everything younger; the head itself retires.
            if (i_squash) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_valid[k] <= 1'b0;
                end
            end else begin
                r_valid[0] <= i_push;
                for (int k = 1; k < DEPTH; k++) begin
                    r_valid[k] <= r_valid[k-1];
                end
            end
            r_type[0] <= i_push_type;
            r_tgt[0]  <= i_push_tgt;
            for (int k = 1; k < DEPTH; k++) begin
                r_type[k] <= r_type[k-1];
                r_tgt[k]  <= r_tgt[k-1];
            end
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            o_any_valid = o_any_valid | r_valid[k];
        end
    end

    assign o_head_valid = r_valid[DEPTH-1];
    assign o_head_type  = r_type[DEPTH-1];
    assign o_head_tgt   = r_tgt[DEPTH-1];

endmodule

// File: rtl/jmp_resolver.sv
// Jump/branch resolution: immediate jump targets, pipelined
// branch evaluation, registered fetch redirect and counters.
module jmp_resolver
    import jmp_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_BITS      = 5,
    parameter int RESOLVE_DEPTH = 2,
    parameter int HAZ_DEPTH     = 2,
    parameter int PC_OFFSET     = 8,
    parameter int CNT_W         = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          jmp_valid,
    input  logic [2:0]                    jmp_type,
    input  logic [REG_BITS-1:0]           jmp_rs,
    input  logic [XLEN-1:0]               rs_val,
    input  logic [XLEN-1:0]               imm,
    input  logic [XLEN-1:0]               pc,
    input  logic [HAZ_DEPTH*REG_BITS-1:0] prev_rd,
    input  logic                          flag_zero,
    input  logic                          flag_lt,
    output logic                          halt,
    output logic                          redirect_valid,
    output logic [XLEN-1:0]               redirect_pc,
    output logic                          flush_branch,
    output logic                          flush_jal,
    output logic [CNT_W-1:0]              br_taken_cnt,
    output logic [CNT_W-1:0]              jmp_cnt
);

    jmp_type_t       w_type;
    logic            w_is_br;
    logic            w_is_jmp;
    logic            w_haz;
    logic            w_any;
    logic            w_head_valid;
    jmp_type_t       w_head_type;
    logic [XLEN-1:0] w_head_tgt;
    logic            w_take;
    logic            w_push;
    logic            w_jmp_acc;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jmp_sum;
    logic [XLEN-1:0] w_jmp_tgt;

    assign w_type   = jmp_type_t'(jmp_type);
    assign w_is_br  = jmp_valid & is_branch(w_type);
    assign w_is_jmp = jmp_valid & !is_branch(w_type);

    always_comb begin
        w_haz = 1'b0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (prev_rd[k*REG_BITS +: REG_BITS] == jmp_rs) begin
                w_haz = 1'b1;
            end
        end
    end

    // Any branch in flight blocks jumps, so the two never retire together.
    assign halt = w_is_jmp & (w_any |
                  ((w_type == JT_JALR) & (jmp_rs != '0) & w_haz));

    assign w_take = w_head_valid & !stall &
                    branch_taken(w_head_type, flag_zero, flag_lt);
    assign w_push    = w_is_br & !stall & !w_take;
    assign w_jmp_acc = w_is_jmp & !halt & !stall;

    assign w_br_tgt  = pc + imm - XLEN'(PC_OFFSET);
    assign w_jmp_sum = rs_val + imm;
    assign w_jmp_tgt = {w_jmp_sum[XLEN-1:1],
                        w_jmp_sum[0] & (w_type != JT_JALR)};

    jmp_branch_pipe #(
        .XLEN  (XLEN),
        .DEPTH (RESOLVE_DEPTH)
    ) u_pipe (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_stall      (stall),
        .i_push       (w_push),
        .i_push_type  (w_type),
        .i_push_tgt   (w_br_tgt),
        .i_squash     (w_take),
        .o_head_valid (w_head_valid),
        .o_head_type  (w_head_type),
        .o_head_tgt   (w_head_tgt),
        .o_any_valid  (w_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_branch   <= 1'b0;
            flush_jal      <= 1'b0;
            br_taken_cnt   <= '0;
            jmp_cnt        <= '0;
        end else begin
            redirect_valid <= w_take | w_jmp_acc;
            flush_branch   <= w_take;
            flush_jal      <= w_jmp_acc;
            if (w_take) begin
                redirect_pc <= w_head_tgt;
            end else if (w_jmp_acc) begin
                redirect_pc <= w_jmp_tgt;
            end
            if (w_take && br_taken_cnt != '1) begin
                br_taken_cnt <= br_taken_cnt + CNT_W'(1);
            end
            if (w_jmp_acc && jmp_cnt != '1) begin
                jmp_cnt <= jmp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jmp_resolver.sv
// Scoreboard bench for jmp_resolver: directed vectors queue
// expected redirects, a monitor matches them on output.
module tb_jmp_resolver;
    import jmp_pkg::*;

    localparam int XLEN = 32;
    localparam int RB   = 5;
    localparam int HD   = 2;
    localparam int CW   = 3;

    logic            clock;
    logic            reset_n;
    logic            stall;
    logic            jmp_valid;
    logic [2:0]      jmp_type;
    logic [RB-1:0]   jmp_rs;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [HD*RB-1:0] prev_rd;
    logic            flag_zero;
    logic            flag_lt;
    logic            halt;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_branch;
    logic            flush_jal;
    logic [CW-1:0]   br_taken_cnt;
    logic [CW-1:0]   jmp_cnt;

    jmp_resolver #(
        .XLEN          (XLEN),
        .REG_BITS      (RB),
        .RESOLVE_DEPTH (2),
        .HAZ_DEPTH     (HD),
        .PC_OFFSET     (8),
        .CNT_W         (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .jmp_valid      (jmp_valid),
        .jmp_type       (jmp_type),
        .jmp_rs         (jmp_rs),
        .rs_val         (rs_val),
        .imm            (imm),
        .pc             (pc),
        .prev_rd        (prev_rd),
        .flag_zero      (flag_zero),
        .flag_lt        (flag_lt),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_branch   (flush_branch),
        .flush_jal      (flush_jal),
        .br_taken_cnt   (br_taken_cnt),
        .jmp_cnt        (jmp_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            jal;
        int              at;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_redirect: got none, required pc=%h at cycle %0d",
                     e.pc, e.at);
        end
        if (redirect_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_redirect: got pc=%h at cycle %0d, required none",
                         redirect_pc, cyc);
            end else begin
                e = sb.pop_front();
                if (e.at != cyc || redirect_pc != e.pc ||
                    flush_branch != !e.jal || flush_jal != e.jal) begin
                    n_fail++;
                    $display("FAIL redirect: got pc=%h cyc=%0d fb=%b fj=%b, required pc=%h cyc=%0d fb=%b fj=%b",
                             redirect_pc, cyc, flush_branch, flush_jal,
                             e.pc, e.at, !e.jal, e.jal);
                end
            end
        end else if (flush_branch || flush_jal) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_flush: got fb=%b fj=%b, required 0 0",
                     flush_branch, flush_jal);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input jmp_type_t t, input logic [XLEN-1:0] p,
                         input logic [XLEN-1:0] v, input logic [XLEN-1:0] i);
        jmp_valid = 1'b1;
        jmp_type  = t;
        pc        = p;
        rs_val    = v;
        imm       = i;
    endtask

    task automatic push_exp(input logic [XLEN-1:0] p, input logic j,
                            input int at);
        exp_t e;
        e.pc  = p;
        e.jal = j;
        e.at  = at;
        sb.push_back(e);
    endtask

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        jmp_valid = 1'b0;
        jmp_type  = 3'b000;
        jmp_rs    = '0;
        rs_val    = '0;
        imm       = '0;
        pc        = '0;
        prev_rd   = '0;
        flag_zero = 1'b0;
        flag_lt   = 1'b0;
        repeat (2) tick();
        chk("rst_redirect_valid", 32'(redirect_valid), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_br_cnt", 32'(br_taken_cnt), 0);
        reset_n = 1'b1;
        tick();

        // BEQ taken
        drive(JT_BEQ, 32'h100, 0, 32'h20);
        flag_zero = 1'b1;
        push_exp(32'h118, 1'b0, cyc + 3);
        #1 chk("halt_branch", 32'(halt), 0);
        tick();
        jmp_valid = 1'b0;
        repeat (4) tick();
        chk("br_cnt_1", 32'(br_taken_cnt), 1);
        chk("jmp_cnt_0", 32'(jmp_cnt), 0);

        // BNE not taken
        drive(JT_BNE, 32'h200, 0, 32'h4);
        tick();
        jmp_valid = 1'b0;
        repeat (6) tick();
        chk("br_cnt_bne", 32'(br_taken_cnt), 1);

        // squash of younger BLT
        flag_lt = 1'b1;
        drive(JT_BEQ, 32'h300, 0, 32'h10);
        push_exp(32'h308, 1'b0, cyc + 3);
        tick();
        drive(JT_BLT, 32'h400, 0, 32'h8);
        tick();
        jmp_valid = 1'b0;
        repeat (5) tick();
        chk("br_cnt_squash", 32'(br_taken_cnt), 2);

        // JALR hazard
        flag_zero = 1'b0;
        flag_lt   = 1'b0;
        drive(JT_JALR, 0, 32'h203, 32'h4);
        jmp_rs  = 5'd5;
        prev_rd = {5'd5, 5'd0};
        #1 chk("halt_jalr_haz", 32'(halt), 1);
        tick();
        prev_rd = '0;
        #1 chk("halt_jalr_clear", 32'(halt), 0);
        push_exp(32'h206, 1'b1, cyc + 1);
        tick();
        jmp_valid = 1'b0;
        repeat (2) tick();
        chk("jmp_cnt_1", 32'(jmp_cnt), 1);

        // JAL held behind a not-taken branch
        drive(JT_BEQ, 32'h500, 0, 0);
        tick();
        drive(JT_JAL, 0, 32'h1000, 32'h40);
        prev_rd = {5'd0, 5'd5};
        #1 chk("halt_jal_c1", 32'(halt), 1);
        tick();
        #1 chk("halt_jal_c2", 32'(halt), 1);
        tick();
        #1 chk("halt_jal_c3", 32'(halt), 0);
        push_exp(32'h1040, 1'b1, cyc + 1);
        tick();
        jmp_valid = 1'b0;
        prev_rd   = '0;
        repeat (3) tick();
        chk("jmp_cnt_2", 32'(jmp_cnt), 2);

        // stall delays the redirect by one cycle
        flag_zero = 1'b1;
        drive(JT_BEQ, 32'h100, 0, 32'h20);
        push_exp(32'h118, 1'b0, cyc + 4);
        tick();
        drive(JT_JAL, 0, 0, 0);
        stall = 1'b1;
        #1 chk("halt_stall", 32'(halt), 1);
        tick();
        stall     = 1'b0;
        jmp_valid = 1'b0;
        repeat (5) tick();
        chk("br_cnt_stall", 32'(br_taken_cnt), 3);
        chk("jmp_cnt_stall", 32'(jmp_cnt), 2);

        // mid-flight reset discards the branch
        drive(JT_BEQ, 32'h100, 0, 32'h20);
        tick();
        jmp_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_valid", 32'(redirect_valid), 0);
        chk("rst_mid_pc", redirect_pc, 0);
        chk("rst_mid_jcnt", 32'(jmp_cnt), 0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rst_after_pc", redirect_pc, 0);
        chk("rst_after_bcnt", 32'(br_taken_cnt), 0);

        // back-to-back jumps saturate the counter
        for (int i = 0; i < 9; i++) begin
            drive(JT_JAL, 0, 32'(i * 16), 32'h4);
            push_exp(32'(i * 16 + 4), 1'b1, cyc + 1);
            tick();
        end
        jmp_valid = 1'b0;
        repeat (3) tick();
        chk("jmp_cnt_sat", 32'(jmp_cnt), 7);
        chk("br_cnt_sat0", 32'(br_taken_cnt), 0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
